// File: rtl/iir_sos_scheduler_if.sv
// iir_sos_scheduler_if: sample input, engine issue/return and cascade output bundle
// master is the scheduler side; slave is the source/engine/sink side.
interface iir_sos_scheduler_if #(
    parameter int DW     = 16,
    parameter int SECT_W = 3
);
    logic              flush;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic              in_ready;
    logic              sect_start;
    logic [SECT_W-1:0] sect_idx;
    logic [7:0]        coef_base;
    logic [DW-1:0]     sect_x;
    logic              sect_done;
    logic [DW-1:0]     sect_y;
    logic              out_valid;
    logic [DW-1:0]     out_data;
    logic              out_ready;
    logic              busy;
    logic              err_timeout;
    logic [15:0]       sample_cnt;

    modport master (
        input  flush, in_valid, in_data, sect_done, sect_y, out_ready,
        output in_ready, sect_start, sect_idx, coef_base, sect_x,
               out_valid, out_data, busy, err_timeout, sample_cnt
    );

    modport slave (
        output flush, in_valid, in_data, sect_done, sect_y, out_ready,
        input  in_ready, sect_start, sect_idx, coef_base, sect_x,
               out_valid, out_data, busy, err_timeout, sample_cnt
    );
endinterface

// File: rtl/iir_sos_scheduler.sv
// iir_sos_scheduler: runs NUM_SECT cascaded biquad sections through one shared engine per sample.
// Optional IIR_SCHED_BYPASS_EN adds byp_mask to skip selected sections.
module iir_sos_scheduler #(
    parameter int NUM_SECT = 4,
    parameter int DW       = 16,
    parameter int SECT_W   = 3,
    parameter int TIMEOUT  = 63
) (
    input logic clk,
    input logic rst,
`ifdef IIR_SCHED_BYPASS_EN
    input logic [NUM_SECT-1:0] byp_mask,
`endif
    iir_sos_scheduler_if.master bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    localparam logic [SECT_W:0] NONE = (SECT_W + 1)'(NUM_SECT);

    state_t              state, state_d;
    logic [SECT_W-1:0]   idx, idx_d;
    logic [DW-1:0]       acc, acc_d;
    logic [7:0]          tcnt, tcnt_d;
    logic                err, err_d;
    logic [15:0]         cnt, cnt_d;
    logic [NUM_SECT-1:0] mask_q, mask_d, mask_in;
    logic [SECT_W:0]     first_sect, next_sect;

`ifdef IIR_SCHED_BYPASS_EN
    assign mask_in = byp_mask;
`else
    assign mask_in = '0;
`endif

    // Lowest unmasked section at or above 'from'; NONE when the rest of the cascade is skipped.
    function automatic logic [SECT_W:0] seek(input logic [NUM_SECT-1:0] m, input int from);
        seek = NONE;
        for (int i = NUM_SECT - 1; i >= 0; i--)
            if (i >= from && !m[i]) seek = (SECT_W + 1)'(i);
    endfunction

    assign first_sect = seek(mask_in, 0);
    assign next_sect  = seek(mask_q, int'(idx) + 1);

    always_comb begin
        state_d = state;
        idx_d   = idx;
        acc_d   = acc;
        tcnt_d  = tcnt;
        err_d   = err;
        cnt_d   = cnt;
        mask_d  = mask_q;
        if (bus.flush) begin
            state_d = IDLE;
            idx_d   = '0;
            acc_d   = '0;
            tcnt_d  = '0;
            err_d   = 1'b0;
            mask_d  = '0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    acc_d   = bus.in_data;
                    mask_d  = mask_in;
                    idx_d   = first_sect == NONE ? '0 : first_sect[SECT_W-1:0];
                    state_d = first_sect == NONE ? OUT : ISSUE;
                end
                ISSUE: begin
                    tcnt_d  = '0;
                    state_d = WAIT;
                end
                WAIT: if (bus.sect_done) begin
                    acc_d   = bus.sect_y;
                    tcnt_d  = '0;
                    idx_d   = next_sect == NONE ? idx : next_sect[SECT_W-1:0];
                    state_d = next_sect == NONE ? OUT : ISSUE;
                end else if (tcnt == 8'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    idx_d   = '0;
                    acc_d   = '0;
                    tcnt_d  = '0;
                    state_d = IDLE;
                end else begin
                    tcnt_d  = tcnt + 8'd1;
                end
                OUT: if (bus.out_ready) begin
                    cnt_d   = cnt + 16'd1;
                    idx_d   = '0;
                    state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            idx    <= '0;
            acc    <= '0;
            tcnt   <= '0;
            err    <= 1'b0;
            cnt    <= '0;
            mask_q <= '0;
        end else begin
            state  <= state_d;
            idx    <= idx_d;
            acc    <= acc_d;
            tcnt   <= tcnt_d;
            err    <= err_d;
            cnt    <= cnt_d;
            mask_q <= mask_d;
        end
    end

    assign bus.in_ready    = state == IDLE;
    assign bus.busy        = state != IDLE;
    assign bus.sect_start  = state == ISSUE;
    assign bus.sect_idx    = idx;
    assign bus.coef_base   = 8'({idx, 2'b00}) + 8'(idx);
    assign bus.sect_x      = acc;
    assign bus.out_valid   = state == OUT;
    assign bus.out_data    = state == OUT ? acc : '0;
    assign bus.err_timeout = err;
    assign bus.sample_cnt  = cnt;
endmodule

// File: tb/tb_iir_sos_scheduler.sv
// tb_iir_sos_scheduler: x+1 engine model with latency L, scoreboard of expected outputs and latencies.
module tb_iir_sos_scheduler;
    localparam int NS = 4;
    localparam int DW = 16;
    localparam int SW = 3;
    localparam int L  = 3;

    typedef struct {
        logic [15:0] data;
        int          lat;
        int          t;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    iir_sos_scheduler_if #(.DW(DW), .SECT_W(SW)) bus();
`ifdef IIR_SCHED_BYPASS_EN
    logic [NS-1:0] byp_mask = '0;
`endif

    iir_sos_scheduler #(.NUM_SECT(NS), .DW(DW), .SECT_W(SW), .TIMEOUT(63)) dut (
        .clk(clk),
        .rst(rst),
`ifdef IIR_SCHED_BYPASS_EN
        .byp_mask(byp_mask),
`endif
        .bus(bus)
    );

    exp_t sb[$];
    int   idxq[$];
    int   n_pass = 0;
    int   n_chk = 0;
    int   cyc = 0;
    int   kill_sect = -1;
    int   starts = 0;
    int   outs = 0;
    int   start_cyc[NS];
    logic ov_q = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Engine model: returns x+1, sect_done high during the L-th cycle after the start cycle.
    initial begin
        logic [DW-1:0] ex;
        bus.sect_done = 1'b0;
        bus.sect_y    = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.sect_done = 1'b0;
            if (bus.sect_start && !rst && int'(bus.sect_idx) != kill_sect) begin
                ex = bus.sect_x;
                repeat (L) @(posedge clk);
                #1;
                bus.sect_done = 1'b1;
                bus.sect_y    = 16'(ex + 16'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sect_start) begin
                starts++;
                start_cyc[bus.sect_idx] = cyc;
                if (idxq.size() == 0) check("spurious_start", 32'(1), 32'(0));
                else check("sect_idx", 32'(bus.sect_idx), 32'(idxq.pop_front()));
                check("coef_base", 32'(bus.coef_base), 32'(bus.sect_idx) * 32'd5);
            end
            if (bus.out_valid && !ov_q) begin
                if (sb.size() == 0) check("spurious_out", 32'(1), 32'(0));
                else check("latency", 32'(cyc - sb[0].t), 32'(sb[0].lat));
            end
            if (bus.out_valid && bus.out_ready) begin
                outs++;
                if (sb.size() == 0) check("spurious_hs", 32'(1), 32'(0));
                else check("out_data", 32'(bus.out_data), 32'(sb.pop_front().data));
            end
        end
        ov_q <= bus.out_valid;
    end

    task automatic send(input logic [15:0] x, input logic [NS-1:0] m, input bit exp_out);
        int n = 0;
        int r = 0;
        while (!bus.in_ready && n < 300) begin
            step();
            n++;
        end
        check("in_ready_wait", 32'(bus.in_ready), 32'(1));
        idxq.delete();
        for (int i = 0; i < NS; i++)
            if (!m[i]) begin
                idxq.push_back(i);
                r++;
            end
`ifdef IIR_SCHED_BYPASS_EN
        byp_mask = m;
`endif
        bus.in_valid = 1'b1;
        bus.in_data  = x;
        if (exp_out) sb.push_back('{data: 16'(x + 16'(r)), lat: (r == 0 ? 1 : r * (L + 1) + 1), t: cyc});
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 500) begin
            step();
            n++;
        end
        check("drain", 32'(sb.size()), 32'(0));
    endtask

    initial begin
        int n;
        int s0;
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 32'(bus.in_ready), 32'(1));
        check("rst_busy", 32'(bus.busy), 32'(0));
        check("rst_out_valid", 32'(bus.out_valid), 32'(0));
        check("rst_sect_start", 32'(bus.sect_start), 32'(0));
        check("rst_err", 32'(bus.err_timeout), 32'(0));
        check("rst_cnt", 32'(bus.sample_cnt), 32'(0));
        check("rst_coef", 32'(bus.coef_base), 32'(0));

        send(16'h0010, '0, 1'b1);
        drain();
        check("t1_cnt", 32'(bus.sample_cnt), 32'(1));
        check("t1_starts", 32'(starts), 32'(4));

        bus.out_ready = 1'b0;
        send(16'h0100, '0, 1'b1);
        n = 0;
        while (!bus.out_valid && n < 100) begin
            step();
            n++;
        end
        for (int i = 0; i < 10; i++) begin
            step();
            check("t2_hold_valid", 32'(bus.out_valid), 32'(1));
            check("t2_hold_data", 32'(bus.out_data), 32'h0104);
            check("t2_in_ready", 32'(bus.in_ready), 32'(0));
        end
        bus.out_ready = 1'b1;
        step();
        check("t2_idle", 32'(bus.in_ready), 32'(1));
        check("t2_busy", 32'(bus.busy), 32'(0));
        check("t2_cnt", 32'(bus.sample_cnt), 32'(2));

        kill_sect = 2;
        send(16'h0200, '0, 1'b0);
        n = 0;
        while (!bus.err_timeout && n < 300) begin
            step();
            n++;
        end
        check("t3_err", 32'(bus.err_timeout), 32'(1));
        check("t3_window", 32'((cyc - start_cyc[2]) >= 64 && (cyc - start_cyc[2]) <= 65), 32'(1));
        check("t3_outs", 32'(outs), 32'(2));
        check("t3_busy", 32'(bus.busy), 32'(0));
        check("t3_cnt", 32'(bus.sample_cnt), 32'(2));
        kill_sect = -1;
        step();
        send(16'h0300, '0, 1'b1);
        drain();
        check("t3_cnt_after", 32'(bus.sample_cnt), 32'(3));
        check("t3_sticky", 32'(bus.err_timeout), 32'(1));

        send(16'h0400, '0, 1'b0);
        n = 0;
        forever begin
            @(posedge clk);
            #2;
            if ((bus.sect_done && bus.sect_idx == 3'd1) || n >= 300) break;
            n++;
        end
        check("t4_done_seen", 32'(bus.sect_done), 32'(1));
        bus.flush = 1'b1;
        @(posedge clk);
        #1 bus.flush = 1'b0;
        check("t4_busy", 32'(bus.busy), 32'(0));
        check("t4_in_ready", 32'(bus.in_ready), 32'(1));
        check("t4_err_clr", 32'(bus.err_timeout), 32'(0));
        check("t4_cnt", 32'(bus.sample_cnt), 32'(3));
        check("t4_sect_idx", 32'(bus.sect_idx), 32'(0));
        s0 = starts;
        repeat (8) step();
        check("t4_quiet", 32'(starts), 32'(s0));
        check("t4_outs", 32'(outs), 32'(3));

        send(16'h0500, '0, 1'b0);
        n = 0;
        while (!(bus.sect_start && bus.sect_idx == 3'd1) && n < 100) begin
            step();
            n++;
        end
        step();
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        check("t5_in_ready", 32'(bus.in_ready), 32'(1));
        check("t5_busy", 32'(bus.busy), 32'(0));
        check("t5_cnt", 32'(bus.sample_cnt), 32'(0));
        check("t5_start", 32'(bus.sect_start), 32'(0));
        check("t5_coef", 32'(bus.coef_base), 32'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        s0 = starts;
        repeat (6) step();
        check("t5_ignored", 32'(starts), 32'(s0));
        check("t5_idle", 32'(bus.busy), 32'(0));

        send(16'h7FFF, '0, 1'b1);
        drain();
        check("wrap_cnt", 32'(bus.sample_cnt), 32'(1));

`ifdef IIR_SCHED_BYPASS_EN
        send(16'h1000, 4'b0101, 1'b1);
        drain();
        send(16'h2222, 4'b1111, 1'b1);
        drain();
        check("byp_cnt", 32'(bus.sample_cnt), 32'(3));
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
